// File: rtl/matvec_pkg.sv
// Shared types and width helpers for the matrix-vector stream stages.
package matvec_pkg;

  typedef enum logic {IDLE, BUSY} state_t;

  // Bias sum width: one bit above the wider operand so the add never overflows.
  function automatic int sum_width(input int w_y, input int w_b);
    return ((w_y > w_b) ? w_y : w_b) + 1;
  endfunction

  // Rounding width: one more bit for the half-LSB add before the shift.
  function automatic int rnd_width(input int w_y, input int w_b);
    return sum_width(w_y, w_b) + 1;
  endfunction

endpackage

// File: rtl/requant_elem.sv
// Combinational requantizer for one element.
// Steps: bias add, rounding arithmetic right shift, optional ReLU, saturation to W_O bits.
module requant_elem
  import matvec_pkg::*;
#(
  parameter int W_Y = 19,
  parameter int W_B = 19,
  parameter int W_O = 8,
  parameter int W_S = 5
) (
  input  logic [W_Y-1:0] y,
  input  logic [W_B-1:0] b,
  input  logic [W_S-1:0] shift,
  input  logic           relu,
  output logic [W_O-1:0] data,
  output logic           sat
);

  localparam int SW = sum_width(W_Y, W_B);
  localparam int RW = rnd_width(W_Y, W_B);
  localparam logic signed [RW-1:0] OMAX = {{(RW-W_O+1){1'b0}}, {(W_O-1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN = ~OMAX;

  logic signed [SW-1:0] sum;
  logic [W_S-1:0]       sh;
  logic [RW-1:0]        half;
  logic signed [RW-1:0] rnd;

  // Adding half an output LSB before the arithmetic shift rounds ties toward +inf.
  always_comb begin
    sum  = $signed({{(SW-W_Y){y[W_Y-1]}}, y}) + $signed({{(SW-W_B){b[W_B-1]}}, b});
    sh   = (shift > W_S'(W_Y)) ? W_S'(W_Y) : shift;
    half = (sh == '0) ? '0 : ({{(RW-1){1'b0}}, 1'b1} << (sh - 1'b1));
    rnd  = ($signed({sum[SW-1], sum}) + $signed(half)) >>> sh;
    if (relu && rnd[RW-1]) rnd = '0;
    data = rnd[W_O-1:0];
    sat  = 1'b0;
    if (rnd > OMAX) begin
      data = OMAX[W_O-1:0];
      sat  = 1'b1;
    end else if (rnd < OMIN) begin
      data = OMIN[W_O-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/matvec_requant_ser.sv
// Captures one accumulator vector and streams its requantized rows, row 0 first,
// on a valid/ready output marked with last.
module matvec_requant_ser
  import matvec_pkg::*;
#(
  parameter int R   = 8,
  parameter int W_Y = 19,
  parameter int W_B = 19,
  parameter int W_O = 8,
  localparam int W_S = $clog2(W_Y + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [R*W_Y-1:0] s_y,
  input  logic [R*W_B-1:0] s_bias,
  input  logic [W_S-1:0]   s_shift,
  input  logic             s_relu,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W_O-1:0]   m_data,
  output logic             m_sat,
  output logic             m_last
);

  localparam int IW = $clog2(R);

  state_t         state;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  nxt;
  logic           accept;

  logic [W_Y-1:0] y_row [R];
  logic [W_B-1:0] b_row [R];
  logic [W_Y-1:0] cap_y [R];
  logic [W_B-1:0] cap_b [R];
  logic [W_S-1:0] cap_shift;
  logic           cap_relu;

  logic [W_Y-1:0] ey;
  logic [W_B-1:0] eb;
  logic [W_S-1:0] esh;
  logic           erelu;
  logic [W_O-1:0] q_data;
  logic           q_sat;

  for (genvar g = 0; g < R; g++) begin : g_rows
    assign y_row[g] = s_y[g*W_Y +: W_Y];
    assign b_row[g] = s_bias[g*W_B +: W_B];
  end

  assign accept = (state == IDLE) && s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_y     <= y_row;
      cap_b     <= b_row;
      cap_shift <= s_shift;
      cap_relu  <= s_relu;
    end
  end

  // In IDLE the live input row 0 is requantized so element 0 is ready at the accept edge.
  always_comb begin
    nxt = (idx == IW'(R - 1)) ? '0 : idx + 1'b1;
    if (state == IDLE) begin
      ey    = y_row[0];
      eb    = b_row[0];
      esh   = s_shift;
      erelu = s_relu;
    end else begin
      ey    = cap_y[nxt];
      eb    = cap_b[nxt];
      esh   = cap_shift;
      erelu = cap_relu;
    end
  end

  requant_elem #(
    .W_Y(W_Y),
    .W_B(W_B),
    .W_O(W_O),
    .W_S(W_S)
  ) u_elem (
    .y    (ey),
    .b    (eb),
    .shift(esh),
    .relu (erelu),
    .data (q_data),
    .sat  (q_sat)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      idx     <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sat   <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (accept) begin
            state   <= BUSY;
            s_ready <= 1'b0;
            m_valid <= 1'b1;
            idx     <= '0;
            m_data  <= q_data;
            m_sat   <= q_sat;
            m_last  <= 1'b0;
          end
        end
        BUSY: begin
          if (m_ready) begin
            if (idx == IW'(R - 1)) begin
              state   <= IDLE;
              s_ready <= 1'b1;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end else begin
              idx    <= nxt;
              m_data <= q_data;
              m_sat  <= q_sat;
              m_last <= (idx == IW'(R - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_requant_ser.sv
// Scoreboard bench for matvec_requant_ser: a plain-arithmetic model fills an expected queue,
// a negedge monitor drives m_ready and compares every presented element.
module tb_matvec_requant_ser;

  localparam int R   = 8;
  localparam int W_Y = 19;
  localparam int W_B = 19;
  localparam int W_O = 8;
  localparam int W_S = 5;
  localparam longint OMAX = (longint'(1) << (W_O - 1)) - 1;
  localparam longint OMIN = -(longint'(1) << (W_O - 1));

  typedef struct {
    logic [W_O-1:0] data;
    logic           sat;
    logic           last;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic [R-1:0][W_Y-1:0]   syArr = '0;
  logic [R-1:0][W_B-1:0]   sbArr = '0;
  logic [W_S-1:0]          s_shift = '0;
  logic                    s_relu = 1'b0;
  logic                    m_valid;
  logic                    m_ready = 1'b1;
  logic [W_O-1:0]          m_data;
  logic                    m_sat;
  logic                    m_last;

  exp_t   expQ[$];
  int     checks = 0;
  int     errors = 0;
  int     popCount = 0;
  bit     readyMode = 1'b0;
  longint vy[R];
  longint vb[R];
  int     vShift;
  bit     vRelu;

  bit             readyNext = 1'b0;
  bit             validNext = 1'b0;
  bit             stalled = 1'b0;
  logic [W_O-1:0] prevData;
  logic           prevSat;
  logic           prevLast;

  matvec_requant_ser #(
    .R  (R),
    .W_Y(W_Y),
    .W_B(W_B),
    .W_O(W_O)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_y    (syArr),
    .s_bias (sbArr),
    .s_shift(s_shift),
    .s_relu (s_relu),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_sat  (m_sat),
    .m_last (m_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: exact integer arithmetic with floor division for the rounding shift.
  function automatic void refElem(input longint y, input longint b, input int shift,
                                  input bit relu, output logic [W_O-1:0] d, output logic s);
    longint sum, num, p, rnd;
    int     sh;
    sum = y + b;
    sh  = (shift > W_Y) ? W_Y : shift;
    if (sh == 0) begin
      rnd = sum;
    end else begin
      p   = longint'(1) << sh;
      num = sum + p / 2;
      rnd = num / p;
      if ((num % p) != 0 && num < 0) rnd = rnd - 1;
    end
    if (relu && rnd < 0) rnd = 0;
    s = 1'b0;
    if (rnd > OMAX) begin
      rnd = OMAX;
      s   = 1'b1;
    end else if (rnd < OMIN) begin
      rnd = OMIN;
      s   = 1'b1;
    end
    d = W_O'(rnd);
  endfunction

  // Offer the vector in vy/vb/vShift/vRelu; expected rows are queued when the DUT accepts.
  task automatic applyStimulus(input bit hold);
    logic [W_O-1:0] d;
    logic           s;
    bit             accepted;
    accepted = 1'b0;
    @(negedge clk);
    for (int r = 0; r < R; r++) begin
      syArr[r] = vy[r][W_Y-1:0];
      sbArr[r] = vb[r][W_B-1:0];
    end
    s_shift = W_S'(vShift);
    s_relu  = vRelu;
    s_valid = 1'b1;
    for (int c = 0; c < 300 && !accepted; c++) begin
      if (s_ready) accepted = 1'b1;
      else @(negedge clk);
    end
    if (!accepted) begin
      checkOutput("accept_timeout", 0, 1);
      s_valid = 1'b0;
    end else begin
      for (int r = 0; r < R; r++) begin
        refElem(vy[r], vb[r], vShift, vRelu, d, s);
        expQ.push_back('{data: d, sat: s, last: (r == R - 1)});
      end
      @(posedge clk);
      #1 s_valid = hold;
      @(negedge clk);
      checkOutput("accept_latency_valid", longint'(m_valid), 1);
    end
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      #1 if (expQ.size() == 0 && !m_valid) done = 1'b1;
    end
    if (!done) checkOutput("drain_timeout", longint'(expQ.size()), 0);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #2 rstn = 1'b1;
    #1 checkOutput("ready_before_first_edge", longint'(s_ready), 0);
    @(posedge clk);
    #1 checkOutput("ready_first_edge", longint'(s_ready), 1);
  endtask

  task automatic doReset();
    @(posedge clk);
    #2 rstn = 1'b0;
    s_valid = 1'b0;
    #1;
    checkOutput("rst_m_valid", longint'(m_valid), 0);
    checkOutput("rst_m_data", longint'(m_data), 0);
    checkOutput("rst_s_ready", longint'(s_ready), 0);
    repeat (3) @(posedge clk);
    releaseReset();
  endtask

  task automatic randomVector();
    for (int r = 0; r < R; r++) begin
      vy[r] = longint'($urandom_range(0, (1 << W_Y) - 1)) - (longint'(1) << (W_Y - 1));
      vb[r] = longint'($urandom_range(0, (1 << W_B) - 1)) - (longint'(1) << (W_B - 1));
    end
    vShift = int'($urandom_range(0, (1 << W_S) - 1));
    vRelu  = 1'($urandom_range(0, 1));
  endtask

  task automatic clearVector(input int shift, input bit relu);
    for (int r = 0; r < R; r++) begin
      vy[r] = 0;
      vb[r] = 0;
    end
    vShift = shift;
    vRelu  = relu;
  endtask

  // Monitor: decides m_ready for the coming edge, then checks whatever the DUT presents.
  always @(negedge clk) begin
    exp_t e;
    m_ready = readyMode ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (!rstn) begin
      expQ.delete();
      readyNext = 1'b0;
      validNext = 1'b0;
      stalled   = 1'b0;
    end else begin
      if (readyNext) begin
        checkOutput("ready_after_last", longint'(s_ready), 1);
        readyNext = 1'b0;
      end
      if (validNext) begin
        checkOutput("next_elem_valid", longint'(m_valid), 1);
        validNext = 1'b0;
      end
      if (stalled) begin
        checkOutput("stall_hold_data", longint'(m_data), longint'(prevData));
        checkOutput("stall_hold_sat", longint'(m_sat), longint'(prevSat));
        checkOutput("stall_hold_last", longint'(m_last), longint'(prevLast));
      end
      if (m_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          e = expQ[0];
          checkOutput("m_data", longint'($signed(m_data)), longint'($signed(e.data)));
          checkOutput("m_sat", longint'(m_sat), longint'(e.sat));
          checkOutput("m_last", longint'(m_last), longint'(e.last));
          if (m_ready) begin
            void'(expQ.pop_front());
            popCount++;
            if (e.last) readyNext = 1'b1;
            else validNext = 1'b1;
          end
        end
        stalled  = !m_ready;
        prevData = m_data;
        prevSat  = m_sat;
        prevLast = m_last;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    int base;
    bit hit;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("init_m_valid", longint'(m_valid), 0);
    checkOutput("init_m_data", longint'(m_data), 0);
    checkOutput("init_s_ready", longint'(s_ready), 0);
    releaseReset();

    $display("[TB] basic ramp");
    clearVector(4, 1'b0);
    for (int r = 0; r < R; r++) vy[r] = 16 * r;
    applyStimulus(1'b0);
    waitDrain();

    $display("[TB] rounding and bias");
    clearVector(4, 1'b0);
    vy[0] = 24;
    vy[1] = -24;
    vy[2] = 23;
    vb[3] = -40;
    vy[4] = -8;
    vy[5] = 8;
    applyStimulus(1'b0);
    waitDrain();
    clearVector(25, 1'b0);
    vy[0] = 1000;
    vy[1] = 200000;
    applyStimulus(1'b0);
    waitDrain();

    $display("[TB] saturation and relu");
    clearVector(0, 1'b0);
    vy[0] = 100000;
    vy[1] = -100000;
    vy[2] = 127;
    vy[3] = -128;
    vy[4] = 128;
    vy[5] = -129;
    applyStimulus(1'b0);
    waitDrain();
    clearVector(0, 1'b1);
    vy[0] = -5;
    vy[1] = -100000;
    vy[2] = 100000;
    vy[3] = 5;
    applyStimulus(1'b0);
    waitDrain();

    $display("[TB] random vectors with backpressure");
    readyMode = 1'b1;
    for (int n = 0; n < 8; n++) begin
      randomVector();
      applyStimulus(1'b1);
    end
    s_valid = 1'b0;
    waitDrain();
    readyMode = 1'b0;

    $display("[TB] reset mid-vector");
    randomVector();
    base = popCount;
    applyStimulus(1'b0);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk);
      if (popCount >= base + 3) hit = 1'b1;
    end
    if (!hit) checkOutput("third_handshake_timeout", longint'(popCount - base), 3);
    doReset();
    randomVector();
    applyStimulus(1'b0);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matvec_requant_ser.md
# matvec_requant_ser

Downstream stage of the matrix-vector multiplier. Accepts one completed result vector (R signed accumulator words) per handshake and applies per-row bias add, a rounding arithmetic right shift, optional ReLU and saturation to W_O bits. It then serializes the R results, row 0 first, onto a valid/ready stream with a last marker, for the activation buffer or the next layer's input loader.

## Interface
- R, 8: rows per vector; must be ≥2.
- W_Y, 19: accumulator width; matches multiplier output for W_X=W_K=8, C=8.
- W_B, 19: bias width, signed.
- W_O, 8: output width, signed.
- W_S, localparam $clog2(W_Y+1): shift port width.
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- s_valid  in  1  input vector valid.
- s_ready  out  1  block can accept a vector.
- s_y  in  R×W_Y  signed accumulators; element r is row r.
- s_bias  in  R×W_B  signed per-row bias.
- s_shift  in  W_S  right-shift amount; values >W_Y behave as W_Y.
- s_relu  in  1  clamp negative results to 0.
- m_valid  out  1  output element valid.
- m_ready  in  1  downstream accepts element.
- m_data  out  W_O  signed requantized element.
- m_sat  out  1  saturation occurred for this element.
- m_last  out  1  element is row R-1.

## Operation
- FSM: IDLE, BUSY.
- IDLE: s_ready=1 and m_valid=0. When s_valid&&s_ready, the block captures s_y, s_bias, s_shift and s_relu, loads the output register with element 0, sets idx=0 and moves to BUSY.
- BUSY: s_ready=0 and m_valid=1. On m_valid&&m_ready:
  - if idx<R-1: idx++ and the output register loads element idx+1 from the captured vector;
  - if idx==R-1: go to IDLE and m_valid drops.
- m_last = BUSY && idx==R-1.
- While m_valid=1 and m_ready=0, m_data, m_sat and m_last hold stable.
- s_valid during BUSY is ignored. The upstream producer must hold its vector until s_ready.
- Per-element arithmetic, all signed:
  - sum = sext(y) + sext(b), width max(W_Y,W_B)+1 with no overflow;
  - sh = min(shift, W_Y);
  - rnd = sh==0 ? sum : (sum + 2^(sh-1)) >>> sh, arithmetic shift, rounding half toward +∞, one extra bit of width for the add;
  - if relu and rnd<0, then rnd=0;
  - saturate rnd to [-2^(W_O-1), 2^(W_O-1)-1]; m_sat=1 only when clamping to these limits changed the value. ReLU alone never sets m_sat.
- Reset: state=IDLE, idx=0, m_valid=0, m_data=0, m_sat=0, s_ready=0. Capture registers are not reset.
  - Assertion mid-vector drops m_valid immediately and discards the remaining elements.

## Timing
- s_ready is registered: 0 during reset, 1 on the first clk edge after rstn deasserts.
- Accept at edge t: m_valid=1 with element 0 after t. Each element takes one cycle at minimum.
- With m_ready tied to 1, element k appears after edge t+k and m_last after t+R-1. The last handshake occurs at edge t+R, after which s_ready=1.
- Next accept is possible at edge t+R+1. Sustained throughput is one vector per R+1 cycles.
- No combinational path from m_ready or s_valid to any output.

## Structure
- Package matvec_pkg holds:
  - the rounding/saturation width localparams helper;
  - the state enum typedef (IDLE, BUSY), shared with other stream stages.
- Sub-module requant_elem: purely combinational; ports y, b, shift, relu → data, sat. One instance is fed by a mux: the s_* row 0 in IDLE, the captured row idx+1 in BUSY.
- Top holds the FSM, idx counter, capture registers and output register.

## Test plan
- Reset: rstn=0 mid-run → m_valid=0, m_data=0, s_ready=0 at once. After release, s_ready=1 on the first edge.
- Basic: s_y[i]=16·i, bias 0, shift 4, relu 0, m_ready=1 → m_data 0..7 on consecutive cycles, m_last only with 7, s_ready=1 one cycle after the last handshake.
- Rounding and bias, shift 4:
  - y=24 → 2;
  - y=-24 → -1;
  - y=23 → 1;
  - y=0, b=-40 → -2.
  - shift 25 with y=1000 → 0 (clamped to 19).
- Saturation and ReLU, shift 0:
  - y=100000 → 127, m_sat=1;
  - y=-100000 → -128, m_sat=1;
  - with relu=1, y=-5 → 0, m_sat=0;
  - with relu=1, y=-100000 → 0, m_sat=0.
- Backpressure: random m_ready with s_valid held high → m_data, m_sat and m_last stable while stalled, order 0..R-1 preserved, no second vector accepted before IDLE.
- Reset after the third output handshake → m_valid drops. A new vector after release streams from row 0 with the correct values.
